bg_scroll: RTL and testbench

//  Top-level scrolling road background for the car game on the DE1-SoC VGA port.

---
 rtl/bg_scroll.sv | 156 +++++++++++++++
 tb/tb_bg_scroll.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_scroll.sv
`default_nettype none
// bg_scroll: 640x480@60 VGA timing from CLOCK_50 and a vertically scrolling road background
// drawn on a 160x120 grid of 4x4 pixel blocks. Timing geometry is parameterised (defaults are VGA).
module bg_scroll #(
  parameter int TICKS_HALF    = 25_000_000,
  parameter int TICKS_QUARTER = 12_500_000,
  parameter int TICKS_EIGHTH  = 6_250_000,
  parameter int ROWS          = 120,
  parameter int H_VISIBLE     = 640,
  parameter int H_SYNC_START  = 656,
  parameter int H_SYNC_END    = 751,
  parameter int H_TOTAL       = 800,
  parameter int V_VISIBLE     = 480,
  parameter int V_SYNC_START  = 490,
  parameter int V_SYNC_END    = 491,
  parameter int V_TOTAL       = 525
) (
  input  logic       CLOCK_50,
  input  logic [3:0] SW,
  input  logic [3:0] KEY,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK
);

  localparam int TICK_MAX = (TICKS_HALF > TICKS_QUARTER)
                          ? ((TICKS_HALF > TICKS_EIGHTH) ? TICKS_HALF : TICKS_EIGHTH)
                          : ((TICKS_QUARTER > TICKS_EIGHTH) ? TICKS_QUARTER : TICKS_EIGHTH);
  localparam int TW = $clog2(TICK_MAX + 1);
  localparam int OW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic          rst;
  logic          pix_en;
  logic [9:0]    h;
  logic [9:0]    v;
  logic [OW-1:0] offset;
  logic [TW-1:0] tick;
  logic [TW-1:0] period;
  logic [1:0]    sel;
  logic [1:0]    sel_q;
  logic          pending;
  logic          tick_wrap;
  logic          frame_wrap;
  logic [7:0]    x;
  logic [6:0]    y;
  logic [7:0]    ay_sum;
  logic [7:0]    ay;
  logic          visible;
  logic          hs_active;
  logic          vs_active;
  logic [23:0]   colour;
  logic          unused_bits;

  assign rst         = SW[3];
  assign VGA_CLK     = pix_en;
  assign VGA_SYNC_N  = 1'b0;
  assign unused_bits = ^{KEY, ay[7:4]};

  // Speed select: SW[2] has highest priority; code 0 means paused.
  always_comb begin
    sel    = 2'd0;
    period = '0;
    if (SW[2]) begin
      sel    = 2'd3;
      period = TW'(TICKS_HALF);
    end else if (SW[1]) begin
      sel    = 2'd2;
      period = TW'(TICKS_QUARTER);
    end else if (SW[0]) begin
      sel    = 2'd1;
      period = TW'(TICKS_EIGHTH);
    end
  end

  assign tick_wrap  = (sel != 2'd0) && (sel == sel_q) && (tick == period - 1'b1);
  assign frame_wrap = pix_en && (h == 10'(H_TOTAL - 1)) && (v == 10'(V_TOTAL - 1));

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      tick    <= '0;
      sel_q   <= 2'd0;
      pending <= 1'b0;
    end else begin
      sel_q <= sel;
      if (sel == 2'd0 || sel != sel_q || tick_wrap) begin
        tick <= '0;
      end else begin
        tick <= tick + 1'b1;
      end
      // A tick landing on the frame-wrap cycle stays pending for the next frame.
      pending <= tick_wrap | (pending & ~frame_wrap);
    end
  end

  assign x      = h[9:2];
  assign y      = v[8:2];
  assign ay_sum = {1'b0, y} + 8'(ROWS) - 8'(offset);
  assign ay     = (ay_sum >= 8'(ROWS)) ? (ay_sum - 8'(ROWS)) : ay_sum;

  always_comb begin
    colour = 24'h606060;
    if (x < 8'd40 || x >= 8'd120) begin
      colour = 24'h00A000;
    end else if (x == 8'd40 || x == 8'd41 || x == 8'd118 || x == 8'd119) begin
      colour = 24'hFFFFFF;
    end else if (x >= 8'd78 && x <= 8'd81 && ay[3:0] < 4'd8) begin
      colour = 24'hFFFFFF;
    end
  end

  assign visible   = (h < 10'(H_VISIBLE)) && (v < 10'(V_VISIBLE));
  assign hs_active = (h >= 10'(H_SYNC_START)) && (h <= 10'(H_SYNC_END));
  assign vs_active = (v >= 10'(V_SYNC_START)) && (v <= 10'(V_SYNC_END));

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      pix_en      <= 1'b0;
      h           <= '0;
      v           <= '0;
      offset      <= '0;
      VGA_R       <= 8'd0;
      VGA_G       <= 8'd0;
      VGA_B       <= 8'd0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h == 10'(H_TOTAL - 1)) begin
          h <= '0;
          v <= (v == 10'(V_TOTAL - 1)) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
        // Offset only moves between frames so a frame is never torn.
        if (frame_wrap && pending) begin
          offset <= (offset == OW'(ROWS - 1)) ? '0 : offset + 1'b1;
        end
        VGA_BLANK_N <= visible;
        VGA_HS      <= ~hs_active;
        VGA_VS      <= ~vs_active;
        VGA_R       <= visible ? colour[23:16] : 8'd0;
        VGA_G       <= visible ? colour[15:8]  : 8'd0;
        VGA_B       <= visible ? colour[7:0]   : 8'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bg_scroll.sv
`default_nettype none
// tb_bg_scroll: directed checks on a full-geometry instance (timing, pixels) and a
// shrunken-geometry instance (frame counts, scrolling, speed select, wrap, reset).
module tb_bg_scroll;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int rel_f   = 0;
  int rel_s   = 0;

  logic [3:0] sw_f, sw_s;
  logic [3:0] key = 4'b0000;
  logic [7:0] r_f, g_f, b_f, r_s, g_s, b_s;
  logic hs_f, vs_f, bn_f, sn_f, vclk_f;
  logic hs_s, vs_s, bn_s, sn_s, vclk_s;
  logic [23:0] rgb_f, rgb_s;
  assign rgb_f = {r_f, g_f, b_f};
  assign rgb_s = {r_s, g_s, b_s};

  bg_scroll #(
    .TICKS_HALF(400), .TICKS_QUARTER(200), .TICKS_EIGHTH(100), .ROWS(120)
  ) dut_f (
    .CLOCK_50(clk), .SW(sw_f), .KEY(key),
    .VGA_R(r_f), .VGA_G(g_f), .VGA_B(b_f),
    .VGA_HS(hs_f), .VGA_VS(vs_f), .VGA_BLANK_N(bn_f), .VGA_SYNC_N(sn_f), .VGA_CLK(vclk_f)
  );

  // Small geometry: 12 px/line (8 visible, HS 9..10), 6 lines (4 visible, VS at 5) = 144 clocks/frame.
  bg_scroll #(
    .TICKS_HALF(400), .TICKS_QUARTER(200), .TICKS_EIGHTH(100), .ROWS(8),
    .H_VISIBLE(8), .H_SYNC_START(9), .H_SYNC_END(10), .H_TOTAL(12),
    .V_VISIBLE(4), .V_SYNC_START(5), .V_SYNC_END(5), .V_TOTAL(6)
  ) dut_s (
    .CLOCK_50(clk), .SW(sw_s), .KEY(key),
    .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s),
    .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_BLANK_N(bn_s), .VGA_SYNC_N(sn_s), .VGA_CLK(vclk_s)
  );

  // Counts offset changes that do not land on the frame start.
  int midframe = 0;
  int last_off = 0;
  always @(negedge clk) begin
    if (int'(dut_s.offset) != last_off) begin
      if (dut_s.h != 10'd0 || dut_s.v != 10'd0) midframe = midframe + 1;
      last_off = int'(dut_s.offset);
    end
  end

  task automatic wait_fc(input int k);
    while (cyc < rel_f + k) @(negedge clk);
  endtask

  task automatic wait_s(input int k);
    while (cyc < rel_s + k) @(negedge clk);
  endtask

  task automatic reset_small(input logic [3:0] sw);
    sw_s = 4'b1000;
    repeat (2) @(negedge clk);
    sw_s  = sw;
    rel_s = cyc;
  endtask

  task automatic test_reset;
    sw_f = 4'b1000;
    repeat (3) @(negedge clk);
    n_tests += 6;
    if (hs_f !== 1'b1) begin n_fail++; $display("FAIL reset_hs: got %b expected 1", hs_f); end
    if (vs_f !== 1'b1) begin n_fail++; $display("FAIL reset_vs: got %b expected 1", vs_f); end
    if (bn_f !== 1'b0) begin n_fail++; $display("FAIL reset_blank: got %b expected 0", bn_f); end
    if (vclk_f !== 1'b0) begin n_fail++; $display("FAIL reset_vclk: got %b expected 0", vclk_f); end
    if (rgb_f !== 24'h0) begin n_fail++; $display("FAIL reset_rgb: got %h expected 000000", rgb_f); end
    if (sn_f !== 1'b0) begin n_fail++; $display("FAIL sync_n: got %b expected 0", sn_f); end
    sw_f  = 4'b0000;
    rel_f = cyc;
    for (int k = 1; k <= 4; k++) begin
      wait_fc(k);
      n_tests++;
      if (vclk_f !== 1'(k % 2)) begin
        n_fail++; $display("FAIL vga_clk_%0d: got %b expected %0d", k, vclk_f, k % 2);
      end
    end
  endtask

  // Pixel p = v*800+h is on the outputs after clock 2p+2 following reset release.
  task automatic test_pixels_row0;
    int          pix [5] = '{161, 241, 329, 477, 481};
    logic [23:0] exp [5] = '{24'hFFFFFF, 24'h606060, 24'h606060, 24'hFFFFFF, 24'h00A000};
    for (int i = 0; i < 5; i++) begin
      wait_fc(2 * pix[i] + 2);
      n_tests++;
      if (rgb_f !== exp[i]) begin
        n_fail++; $display("FAIL pixel_row0_p%0d: got %h expected %h", pix[i], rgb_f, exp[i]);
      end
    end
  endtask

  task automatic test_line_timing;
    int   pix  [7] = '{639, 640, 655, 656, 751, 752, 1456};
    logic ebn  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic ehs  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [23:0] ergb [7] = '{24'h00A000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
    for (int i = 0; i < 7; i++) begin
      wait_fc(2 * pix[i] + 2);
      n_tests += 3;
      if (bn_f !== ebn[i]) begin
        n_fail++; $display("FAIL blank_p%0d: got %b expected %b", pix[i], bn_f, ebn[i]);
      end
      if (hs_f !== ehs[i]) begin
        n_fail++; $display("FAIL hsync_p%0d: got %b expected %b", pix[i], hs_f, ehs[i]);
      end
      if (rgb_f !== ergb[i]) begin
        n_fail++; $display("FAIL rgb_p%0d: got %h expected %h", pix[i], rgb_f, ergb[i]);
      end
    end
  endtask

  task automatic test_pixels_deep;
    // (79,3) dash on, (10,5) grass, (79,12) dash gap
    int          pix [3] = '{13 * 800 + 317, 21 * 800 + 41, 49 * 800 + 317};
    logic [23:0] exp [3] = '{24'hFFFFFF, 24'h00A000, 24'h606060};
    for (int i = 0; i < 3; i++) begin
      wait_fc(2 * pix[i] + 2);
      n_tests += 2;
      if (rgb_f !== exp[i]) begin
        n_fail++; $display("FAIL pixel_deep_p%0d: got %h expected %h", pix[i], rgb_f, exp[i]);
      end
      if (vs_f !== 1'b1) begin
        n_fail++; $display("FAIL vsync_visible_p%0d: got %b expected 1", pix[i], vs_f);
      end
    end
  endtask

  task automatic test_frame_counts;
    int cnt_bn, cnt_hs, cnt_vs, cnt_bad;
    cnt_bn = 0; cnt_hs = 0; cnt_vs = 0; cnt_bad = 0;
    reset_small(4'b0000);
    for (int k = 2; k < 290; k++) begin
      wait_s(k);
      if (bn_s === 1'b1) cnt_bn++;
      if (hs_s === 1'b0) cnt_hs++;
      if (vs_s === 1'b0) cnt_vs++;
      if (bn_s !== 1'b1 && rgb_s !== 24'h0) cnt_bad++;
    end
    n_tests += 4;
    if (cnt_bn !== 128) begin n_fail++; $display("FAIL frames_blank_cycles: got %0d expected 128", cnt_bn); end
    if (cnt_hs !== 48) begin n_fail++; $display("FAIL frames_hs_cycles: got %0d expected 48", cnt_hs); end
    if (cnt_vs !== 48) begin n_fail++; $display("FAIL frames_vs_cycles: got %0d expected 48", cnt_vs); end
    if (cnt_bad !== 0) begin n_fail++; $display("FAIL frames_rgb_in_blank: got %0d expected 0", cnt_bad); end
  endtask

  task automatic test_scroll_step;
    // period 100 < frame 144: one step per frame, extra ticks merge
    int k   [6] = '{143, 144, 287, 288, 431, 432};
    int exp [6] = '{0, 1, 1, 2, 2, 3};
    reset_small(4'b0001);
    for (int i = 0; i < 6; i++) begin
      wait_s(k[i]);
      n_tests++;
      if (int'(dut_s.offset) !== exp[i]) begin
        n_fail++; $display("FAIL scroll_k%0d: offset=%0d expected %0d", k[i], dut_s.offset, exp[i]);
      end
      if (k[i] == 144) begin
        n_tests++;
        if (dut_s.ay !== 8'd7) begin
          n_fail++; $display("FAIL scroll_row0_ay: got %0d expected 7", dut_s.ay);
        end
      end
    end
  endtask

  task automatic test_speed_select;
    int k_half [4] = '{431, 432, 863, 864};
    int e_half [4] = '{0, 1, 1, 2};
    int k_qtr  [3] = '{287, 288, 1000};
    int e_qtr  [3] = '{0, 1, 4};
    reset_small(4'b0100);
    for (int i = 0; i < 4; i++) begin
      wait_s(k_half[i]);
      n_tests++;
      if (int'(dut_s.offset) !== e_half[i]) begin
        n_fail++; $display("FAIL speed_half_k%0d: offset=%0d expected %0d", k_half[i], dut_s.offset, e_half[i]);
      end
    end
    reset_small(4'b0010);
    for (int i = 0; i < 3; i++) begin
      wait_s(k_qtr[i]);
      n_tests++;
      if (int'(dut_s.offset) !== e_qtr[i]) begin
        n_fail++; $display("FAIL speed_quarter_k%0d: offset=%0d expected %0d", k_qtr[i], dut_s.offset, e_qtr[i]);
      end
    end
    reset_small(4'b0111);
    for (int i = 0; i < 2; i++) begin
      wait_s(k_half[i]);
      n_tests++;
      if (int'(dut_s.offset) !== e_half[i]) begin
        n_fail++; $display("FAIL speed_priority_k%0d: offset=%0d expected %0d", k_half[i], dut_s.offset, e_half[i]);
      end
    end
  endtask

  task automatic test_period_change;
    // half-rate for 300 clocks, then quarter: counter restarts, first tick at clock 501
    int k   [3] = '{432, 575, 576};
    int exp [3] = '{0, 0, 1};
    reset_small(4'b0100);
    wait_s(300);
    sw_s = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      wait_s(k[i]);
      n_tests++;
      if (int'(dut_s.offset) !== exp[i]) begin
        n_fail++; $display("FAIL period_change_k%0d: offset=%0d expected %0d", k[i], dut_s.offset, exp[i]);
      end
    end
  endtask

  task automatic test_wrap;
    int k   [3] = '{1008, 1151, 1152};
    int exp [3] = '{7, 7, 0};
    reset_small(4'b0001);
    for (int i = 0; i < 3; i++) begin
      wait_s(k[i]);
      n_tests++;
      if (int'(dut_s.offset) !== exp[i]) begin
        n_fail++; $display("FAIL wrap_k%0d: offset=%0d expected %0d", k[i], dut_s.offset, exp[i]);
      end
    end
    n_tests++;
    if (midframe !== 0) begin
      n_fail++; $display("FAIL midframe_steps: got %0d expected 0", midframe);
    end
  endtask

  task automatic test_async_reset;
    reset_small(4'b0001);
    wait_s(200);
    sw_s = 4'b1000;
    #1;
    n_tests += 6;
    if (dut_s.h !== 10'd0 || dut_s.v !== 10'd0) begin
      n_fail++; $display("FAIL async_hv: got h=%0d v=%0d expected 0 0", dut_s.h, dut_s.v);
    end
    if (dut_s.offset !== 3'd0) begin n_fail++; $display("FAIL async_offset: got %0d expected 0", dut_s.offset); end
    if (hs_s !== 1'b1 || vs_s !== 1'b1) begin
      n_fail++; $display("FAIL async_sync: got hs=%b vs=%b expected 1 1", hs_s, vs_s);
    end
    if (bn_s !== 1'b0) begin n_fail++; $display("FAIL async_blank: got %b expected 0", bn_s); end
    if (vclk_s !== 1'b0) begin n_fail++; $display("FAIL async_vclk: got %b expected 0", vclk_s); end
    if (rgb_s !== 24'h0) begin n_fail++; $display("FAIL async_rgb: got %h expected 000000", rgb_s); end
    @(negedge clk);
    sw_s  = 4'b0000;
    rel_s = cyc;
    wait_s(2);
    n_tests += 2;
    if (dut_s.h !== 10'd1 || dut_s.v !== 10'd0) begin
      n_fail++; $display("FAIL restart_hv: got h=%0d v=%0d expected 1 0", dut_s.h, dut_s.v);
    end
    if (bn_s !== 1'b1) begin n_fail++; $display("FAIL restart_blank: got %b expected 1", bn_s); end
  endtask

  initial begin
    sw_f = 4'b1000;
    sw_s = 4'b1000;
    fork
      begin
        test_reset();
        test_pixels_row0();
        test_line_timing();
        test_pixels_deep();
      end
      begin
        test_frame_counts();
        test_scroll_step();
        test_speed_select();
        test_period_change();
        test_wrap();
        test_async_reset();
      end
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
